// File: rtl/qea_run_sequencer_if.sv
// Handshake and memory-port bundle between the QEA run sequencer and its environment.
// The master modport is the sequencer side and the slave modport is the QEA/host side.
interface qea_run_sequencer_if #(
    parameter int unsigned PE_NUM                  = 4,
    parameter int unsigned DATA_WIDTH              = 32,
    parameter int unsigned STATE_ADDR_WIDTH        = 16,
    parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int unsigned MAX_QBIT_WIDTH          = 6
);
    localparam int unsigned CTX_DATA_WIDTH = 2 * DATA_WIDTH;
    localparam int unsigned WORD_WIDTH     = PE_NUM * 2 * DATA_WIDTH;

    logic                               i_go;
    logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num;
    logic                               s_ctx_valid;
    logic                               s_ctx_ready;
    logic [CTX_DATA_WIDTH-1:0]          s_ctx_data;
    logic                               o_ctx_en;
    logic                               o_ctx_wea;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr;
    logic [CTX_DATA_WIDTH-1:0]          o_ctx_data;
    logic                               o_state_ena;
    logic                               o_state_wea;
    logic [STATE_ADDR_WIDTH-1:0]        o_state_addra;
    logic [WORD_WIDTH-1:0]              o_state_dina;
    logic [WORD_WIDTH-1:0]              i_state_dout;
    logic                               o_start;
    logic                               i_complete;
    logic                               m_out_valid;
    logic                               m_out_ready;
    logic [WORD_WIDTH-1:0]              m_out_data;
    logic                               o_busy;
    logic                               o_done;
    logic                               o_error;
    logic [31:0]                        o_cycles;

    modport master (
        input  i_go, i_qbit_num, i_ins_num, s_ctx_valid, s_ctx_data, i_state_dout,
               i_complete, m_out_ready,
        output s_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data, o_state_ena,
               o_state_wea, o_state_addra, o_state_dina, o_start, m_out_valid, m_out_data,
               o_busy, o_done, o_error, o_cycles
    );

    modport slave (
        output i_go, i_qbit_num, i_ins_num, s_ctx_valid, s_ctx_data, i_state_dout,
               i_complete, m_out_ready,
        input  s_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data, o_state_ena,
               o_state_wea, o_state_addra, o_state_dina, o_start, m_out_valid, m_out_data,
               o_busy, o_done, o_error, o_cycles
    );
endinterface

// File: rtl/qea_run_sequencer.sv
// Sequences one QEA run: context load, state init, start, wait, readout, done.
// Define QEA_SEQ_TIMEOUT_EN to abort a run whose WAIT_DONE phase hits TIMEOUT_CYCLES.
module qea_run_sequencer #(
    parameter int unsigned PE_NUM                  = 4,
    parameter int unsigned DATA_WIDTH              = 32,
    parameter int unsigned STATE_ADDR_WIDTH        = 16,
    parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int unsigned MAX_QBIT_WIDTH          = 6,
    parameter int unsigned NUM_FRAC_BIT            = 30,
    parameter int unsigned TIMEOUT_CYCLES          = 2**20
) (
    input logic               clk,
    input logic               rst,
    qea_run_sequencer_if.master bus
);
    localparam int unsigned STATE_DATA_WIDTH = 2 * DATA_WIDTH;
    localparam int unsigned CTX_DATA_WIDTH   = 2 * DATA_WIDTH;
    localparam int unsigned WORD_WIDTH       = PE_NUM * STATE_DATA_WIDTH;
    localparam int unsigned ADDR_FULL        = STATE_ADDR_WIDTH + 2;
    localparam logic [DATA_WIDTH-1:0] ONE_FIXED = DATA_WIDTH'(1) << NUM_FRAC_BIT;
    localparam logic [WORD_WIDTH-1:0] INIT_WORD =
        {ONE_FIXED, {(WORD_WIDTH - DATA_WIDTH){1'b0}}};

    typedef enum logic [3:0] {
        StIdle, StLoadCtx, StInitState, StStart, StWaitDone, StRdAddr, StRdCap, StOut, StDone
    } state_e;

    state_e                             state_q, state_d;
    logic [MAX_QBIT_WIDTH-1:0]          qbit_q, qbit_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q, ins_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_idx_q, ctx_idx_d;
    logic [STATE_ADDR_WIDTH-1:0]        idx_q, idx_d;
    logic [31:0]                        cnt_q, cnt_d;
    logic [31:0]                        cycles_q, cycles_d;
    logic                               error_q, error_d;
    logic [WORD_WIDTH-1:0]              out_data_q, out_data_d;

    logic [31:0]                 cnt_inc;
    logic [STATE_ADDR_WIDTH-1:0] state_last;
    logic                        qbit_bad;

    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
    // Last state address is 2**(qbit-2)-1; only consulted once qbit_q has been range-checked.
    assign state_last = {STATE_ADDR_WIDTH{1'b1}} >> (ADDR_FULL - 32'(qbit_q));
    assign qbit_bad   = (32'(bus.i_qbit_num) < 32'd2) || (32'(bus.i_qbit_num) > ADDR_FULL);

`ifndef QEA_SEQ_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            qbit_q     <= '0;
            ins_q      <= '0;
            ctx_idx_q  <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            cycles_q   <= '0;
            error_q    <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            qbit_q     <= qbit_d;
            ins_q      <= ins_d;
            ctx_idx_q  <= ctx_idx_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            cycles_q   <= cycles_d;
            error_q    <= error_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        qbit_d     = qbit_q;
        ins_d      = ins_q;
        ctx_idx_d  = ctx_idx_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        cycles_d   = cycles_q;
        error_d    = error_q;
        out_data_d = out_data_q;

        bus.s_ctx_ready   = 1'b0;
        bus.o_ctx_en      = 1'b0;
        bus.o_ctx_wea     = 1'b0;
        bus.o_ctx_addr    = '0;
        bus.o_ctx_data    = '0;
        bus.o_state_ena   = 1'b0;
        bus.o_state_wea   = 1'b0;
        bus.o_state_addra = '0;
        bus.o_state_dina  = '0;
        bus.o_start       = 1'b0;
        bus.m_out_valid   = 1'b0;
        bus.o_done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.i_go) begin
                    qbit_d    = bus.i_qbit_num;
                    ins_d     = bus.i_ins_num;
                    error_d   = 1'b0;
                    ctx_idx_d = '0;
                    idx_d     = '0;
                    if (qbit_bad) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else if (bus.i_ins_num == '0) begin
                        state_d = StInitState;
                    end else begin
                        state_d = StLoadCtx;
                    end
                end
            end
            StLoadCtx: begin
                bus.s_ctx_ready = 1'b1;
                if (bus.s_ctx_valid) begin
                    bus.o_ctx_en   = 1'b1;
                    bus.o_ctx_wea  = 1'b1;
                    bus.o_ctx_addr = ctx_idx_q;
                    bus.o_ctx_data = bus.s_ctx_data;
                    ctx_idx_d      = ctx_idx_q + GATE_CONTEXT_ADDR_WIDTH'(1);
                    if (ctx_idx_q + GATE_CONTEXT_ADDR_WIDTH'(1) == ins_q) state_d = StInitState;
                end
            end
            StInitState: begin
                bus.o_state_ena   = 1'b1;
                bus.o_state_wea   = 1'b1;
                bus.o_state_addra = idx_q;
                bus.o_state_dina  = (idx_q == '0) ? INIT_WORD : '0;
                if (idx_q == state_last) begin
                    idx_d   = '0;
                    state_d = StStart;
                end else begin
                    idx_d = idx_q + STATE_ADDR_WIDTH'(1);
                end
            end
            StStart: begin
                bus.o_start = 1'b1;
                cnt_d       = '0;
                state_d     = StWaitDone;
            end
            StWaitDone: begin
                cnt_d = cnt_inc;
                // o_cycles counts WAIT_DONE cycles including the one that sees completion.
                if (bus.i_complete) begin
                    cycles_d = cnt_inc;
                    state_d  = StRdAddr;
                end
`ifdef QEA_SEQ_TIMEOUT_EN
                else if (cnt_inc == 32'(TIMEOUT_CYCLES)) begin
                    cycles_d = cnt_inc;
                    error_d  = 1'b1;
                    state_d  = StDone;
                end
`endif
            end
            StRdAddr: begin
                bus.o_state_ena   = 1'b1;
                bus.o_state_addra = idx_q;
                state_d           = StRdCap;
            end
            StRdCap: begin
                out_data_d = bus.i_state_dout;
                state_d    = StOut;
            end
            StOut: begin
                bus.m_out_valid = 1'b1;
                if (bus.m_out_ready) begin
                    if (idx_q == state_last) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + STATE_ADDR_WIDTH'(1);
                        state_d = StRdAddr;
                    end
                end
            end
            StDone: begin
                bus.o_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.o_busy     = (state_q != StIdle);
    assign bus.o_error    = error_q;
    assign bus.o_cycles   = cycles_q;
    assign bus.m_out_data = out_data_q;
endmodule

// File: tb/tb_qea_run_sequencer.sv
// Directed bench for qea_run_sequencer: models the QEA state RAM and completion,
// scoreboards context, init, readout and status behaviour across several runs.
module tb_qea_run_sequencer;
    localparam int unsigned PE   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned SAW  = 16;
    localparam int unsigned GCAW = 16;
    localparam int unsigned MQW  = 6;
    localparam int unsigned WW   = PE * 2 * DW;
`ifdef QEA_SEQ_TIMEOUT_EN
    localparam int unsigned TO   = 100;
    localparam int          CMPL = 60;
`else
    localparam int unsigned TO   = 2**20;
    localparam int          CMPL = 500;
`endif
    localparam logic [WW-1:0] INIT_EXP = {32'h4000_0000, 224'h0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qea_run_sequencer_if #(
        .PE_NUM(PE), .DATA_WIDTH(DW), .STATE_ADDR_WIDTH(SAW),
        .GATE_CONTEXT_ADDR_WIDTH(GCAW), .MAX_QBIT_WIDTH(MQW)
    ) bus ();

    qea_run_sequencer #(
        .PE_NUM(PE), .DATA_WIDTH(DW), .STATE_ADDR_WIDTH(SAW),
        .GATE_CONTEXT_ADDR_WIDTH(GCAW), .MAX_QBIT_WIDTH(MQW),
        .NUM_FRAC_BIT(30), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int ctx_wr_cnt, ctx_bad, state_wr_cnt, state_bad, init_bad, start_cnt;
    int rd_cnt, rd_bad, stall_bad, stall_seen, done_cnt;
    logic          clr = 1'b0;
    int            exp_depth = 0;
    bit            ready_slow = 1'b0;
    bit            ctx_gap = 1'b0;
    bit            cmpl_on = 1'b1;
    logic          stall_pend;
    logic [WW-1:0] stall_data;
    logic [WW-1:0] mem [256];
    int            rdy_ph = 0;

    function automatic logic [WW-1:0] pat(input int k);
        return {8{32'(k * 37 + 5)}};
    endfunction

    function automatic logic [63:0] cword(input int n);
        return {32'hC0DE_0000 | 32'(n), 32'(n * 7)};
    endfunction

    // State RAM with 1-cycle read latency; at o_start it checks the init image and
    // then overwrites every word with a distinct pattern for readout checking.
    always @(posedge clk) begin
        if (clr) init_bad <= 0;
        if (bus.o_state_ena && bus.o_state_wea) mem[bus.o_state_addra[7:0]] <= bus.o_state_dina;
        if (bus.o_state_ena && !bus.o_state_wea) bus.i_state_dout <= mem[bus.o_state_addra[7:0]];
        if (bus.o_start) begin
            for (int k = 0; k < 256; k++) begin
                if (k < exp_depth && mem[k] !== ((k == 0) ? INIT_EXP : '0)) init_bad <= init_bad + 1;
                mem[k] <= pat(k);
            end
        end
    end

    always @(negedge clk) begin
        if (clr) begin
            ctx_wr_cnt <= 0; ctx_bad <= 0; state_wr_cnt <= 0; state_bad <= 0; start_cnt <= 0;
            rd_cnt <= 0; rd_bad <= 0; stall_bad <= 0; stall_seen <= 0; done_cnt <= 0;
            stall_pend <= 1'b0;
        end else begin
            if ((bus.o_ctx_en !== (bus.s_ctx_valid && bus.s_ctx_ready)) ||
                (bus.o_ctx_en && (!bus.o_ctx_wea || bus.o_ctx_addr !== 16'(ctx_wr_cnt) ||
                                  bus.o_ctx_data !== cword(ctx_wr_cnt))))
                ctx_bad <= ctx_bad + 1;
            if (bus.o_ctx_en) ctx_wr_cnt <= ctx_wr_cnt + 1;
            if (bus.o_state_ena && bus.o_state_wea) begin
                if (bus.o_state_addra !== 16'(state_wr_cnt)) state_bad <= state_bad + 1;
                state_wr_cnt <= state_wr_cnt + 1;
            end
            if (bus.o_start) start_cnt <= start_cnt + 1;
            if (bus.o_done) done_cnt <= done_cnt + 1;
            if (bus.m_out_valid) begin
                if (stall_pend && bus.m_out_data !== stall_data) stall_bad <= stall_bad + 1;
                if (bus.m_out_ready) begin
                    if (bus.m_out_data !== pat(rd_cnt)) rd_bad <= rd_bad + 1;
                    rd_cnt     <= rd_cnt + 1;
                    stall_pend <= 1'b0;
                end else begin
                    stall_pend <= 1'b1;
                    stall_data <= bus.m_out_data;
                    stall_seen <= stall_seen + 1;
                end
            end else begin
                stall_pend <= 1'b0;
            end
        end
    end

    initial begin
        bus.s_ctx_valid = 1'b0;
        bus.s_ctx_data  = '0;
        forever begin
            @(posedge clk); #1;
            bus.s_ctx_data  = cword(ctx_wr_cnt);
            bus.s_ctx_valid = ctx_gap ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        bus.m_out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.m_out_ready = ready_slow ? (rdy_ph == 0) : 1'b1;
            rdy_ph = (rdy_ph + 1) % 3;
        end
    end

    // QEA completion model: i_complete high for one cycle CMPL cycles after o_start.
    initial begin
        bus.i_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_start && cmpl_on) begin
                repeat (CMPL) @(posedge clk);
                #1 bus.i_complete = 1'b1;
                @(posedge clk);
                #1 bus.i_complete = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic go(input int qbit, input int ins);
        @(posedge clk); #1;
        bus.i_qbit_num = 6'(qbit);
        bus.i_ins_num  = 16'(ins);
        bus.i_go       = 1'b1;
        @(posedge clk); #1;
        bus.i_go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(done_cnt != 0), 64'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n = 0;
        while (start_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(start_cnt != 0), 64'd1);
    endtask

    initial begin
        bus.i_go       = 1'b0;
        bus.i_qbit_num = '0;
        bus.i_ins_num  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_error", bus.o_error, 0);
        chk("rst_cycles", bus.o_cycles, 0);
        chk("rst_strobes", {bus.s_ctx_ready, bus.o_ctx_en, bus.o_state_ena, bus.o_start,
                            bus.m_out_valid}, 0);
        chk("rst_out_data", |bus.m_out_data, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Nominal 8-qubit run with 111 context words.
        clear_counts();
        exp_depth = 64;
        go(8, 111);
        @(negedge clk);
        chk("a_busy", bus.o_busy, 1);
        wait_done("a_done_seen", 4000);
        chk("a_ctx_cnt", ctx_wr_cnt, 111);
        chk("a_ctx_bad", ctx_bad, 0);
        chk("a_state_cnt", state_wr_cnt, 64);
        chk("a_state_addr", state_bad, 0);
        chk("a_init_img", init_bad, 0);
        chk("a_start_cnt", start_cnt, 1);
        chk("a_cycles", bus.o_cycles, CMPL);
        chk("a_rd_cnt", rd_cnt, 64);
        chk("a_rd_data", rd_bad, 0);
        chk("a_done_cnt", done_cnt, 1);
        chk("a_error", bus.o_error, 0);
        chk("a_idle", bus.o_busy, 0);

        // Gapped context, 1-of-3 readout ready, and a go pulse while busy.
        clear_counts();
        ctx_gap = 1'b1;
        ready_slow = 1'b1;
        exp_depth = 4;
        go(4, 20);
        wait_start("b_start_seen", 500);
        repeat (20) @(negedge clk);
        go(1, 3);
        wait_done("b_done_seen", 4000);
        repeat (CMPL + 50) @(negedge clk);
        chk("b_ctx_cnt", ctx_wr_cnt, 20);
        chk("b_ctx_bad", ctx_bad, 0);
        chk("b_init_img", init_bad, 0);
        chk("b_start_cnt", start_cnt, 1);
        chk("b_rd_cnt", rd_cnt, 4);
        chk("b_rd_data", rd_bad, 0);
        chk("b_stall_stable", stall_bad, 0);
        chk("b_stall_seen", 64'(stall_seen != 0), 1);
        chk("b_done_cnt", done_cnt, 1);
        chk("b_error", bus.o_error, 0);
        chk("b_cycles", bus.o_cycles, CMPL);
        ctx_gap = 1'b0;
        ready_slow = 1'b0;

        // Out-of-range qubit counts.
        clear_counts();
        exp_depth = 0;
        go(1, 5);
        wait_done("c_done_seen", 50);
        chk("c_error", bus.o_error, 1);
        chk("c_done_cnt", done_cnt, 1);
        chk("c_no_activity", ctx_wr_cnt + state_wr_cnt + start_cnt + rd_cnt, 0);
        chk("c_idle", bus.o_busy, 0);
        clear_counts();
        go(19, 5);
        wait_done("c19_done_seen", 50);
        chk("c19_error", bus.o_error, 1);
        chk("c19_no_activity", ctx_wr_cnt + state_wr_cnt + start_cnt, 0);

        // Minimum size: qbit 2 (one word), no context.
        clear_counts();
        exp_depth = 1;
        go(2, 0);
        wait_done("d_done_seen", CMPL + 100);
        chk("d_ctx_cnt", ctx_wr_cnt, 0);
        chk("d_state_cnt", state_wr_cnt, 1);
        chk("d_init_img", init_bad, 0);
        chk("d_rd_cnt", rd_cnt, 1);
        chk("d_rd_data", rd_bad, 0);
        chk("d_error_cleared", bus.o_error, 0);
        chk("d_cycles", bus.o_cycles, CMPL);

        // Reset asserted while waiting for completion.
        clear_counts();
        exp_depth = 2;
        cmpl_on = 1'b0;
        go(3, 2);
        wait_start("e_start_seen", 200);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("e_rst_busy", bus.o_busy, 0);
        chk("e_rst_cycles", bus.o_cycles, 0);
        chk("e_rst_error", bus.o_error, 0);
        chk("e_rst_strobes", {bus.s_ctx_ready, bus.o_ctx_en, bus.o_state_ena, bus.o_start,
                              bus.m_out_valid, bus.o_done}, 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;

        clear_counts();
`ifdef QEA_SEQ_TIMEOUT_EN
        go(3, 2);
        wait_done("f_done_seen", 400);
        chk("f_error", bus.o_error, 1);
        chk("f_cycles", bus.o_cycles, 100);
        chk("f_rd_cnt", rd_cnt, 0);
        chk("f_start_cnt", start_cnt, 1);
        chk("f_ctx_cnt", ctx_wr_cnt, 2);
        chk("f_init_img", init_bad, 0);
`else
        cmpl_on = 1'b1;
        go(3, 2);
        wait_done("f_done_seen", CMPL + 200);
        chk("f_error", bus.o_error, 0);
        chk("f_cycles", bus.o_cycles, CMPL);
        chk("f_rd_cnt", rd_cnt, 2);
        chk("f_rd_data", rd_bad, 0);
        chk("f_start_cnt", start_cnt, 1);
        chk("f_ctx_cnt", ctx_wr_cnt, 2);
        chk("f_init_img", init_bad, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/qea_run_sequencer.md
QEA_RUN_SEQUENCER -- requirements
Module: qea_run_sequencer

Interface
REQ-001 SHALL have parameters: PE_NUM, default 4, number of PE lanes per state word.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per real or imaginary part.
REQ-003 SHALL have parameter STATE_ADDR_WIDTH, default 16; GATE_CONTEXT_ADDR_WIDTH, default 16; MAX_QBIT_WIDTH, default 6; NUM_FRAC_BIT, default 30; TIMEOUT_CYCLES, default 2**20.
REQ-004 SHALL derive STATE_DATA_WIDTH = 2*DATA_WIDTH and CTX_DATA_WIDTH = 2*DATA_WIDTH internally.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 Ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- i_go  in  1  start a run; honoured only in IDLE.
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count.
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context words to load.
- s_ctx_valid / s_ctx_ready  in / out  1  context stream handshake.
- s_ctx_data  in  CTX_DATA_WIDTH  context word.
- o_ctx_en, o_ctx_wea  out  1  QEA context write strobes.
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context address.
- o_ctx_data  out  CTX_DATA_WIDTH  context word.
- o_state_ena, o_state_wea  out  1  QEA state port enable / write.
- o_state_addra  out  STATE_ADDR_WIDTH  state address.
- o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state write word.
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state read word; 1-cycle read latency.
- o_start  out  1  one-cycle QEA start pulse.
- i_complete  in  1  QEA completion level.
- m_out_valid / m_out_ready  out / in  1  readout stream handshake.
- m_out_data  out  PE_NUM*STATE_DATA_WIDTH  readout word.
- o_busy, o_done, o_error  out  1  status.
- o_cycles  out  32  execution cycles of the last run.

Function
REQ-007 FSM states: IDLE, LOAD_CTX, INIT_STATE, START, WAIT_DONE, RD_ADDR, RD_CAP, OUT, DONE.
REQ-008 IDLE with i_go=1 SHALL latch i_qbit_num and i_ins_num, clear o_error, and go to LOAD_CTX. If the latched i_qbit_num<2 or >STATE_ADDR_WIDTH+2, it SHALL instead set o_error and go to DONE.
REQ-009 LOAD_CTX:
- s_ctx_ready=1.
- Each accepted beat (valid&ready) SHALL drive o_ctx_en=o_ctx_wea=1 with addr=beat index, starting at 0, in the same cycle.
- After i_ins_num beats go to INIT_STATE.
- With i_ins_num=0, go directly to INIT_STATE.
REQ-010 INIT_STATE SHALL write DEPTH=2**(qbit_num-2) words, one per cycle, at addresses 0..DEPTH-1, with ena=wea=1.
- Word 0: bits [PE_NUM*STATE_DATA_WIDTH-1 -: DATA_WIDTH] = 1<<NUM_FRAC_BIT, all other bits 0.
- Other words: all zero.
REQ-011 START SHALL assert o_start for exactly one cycle, clear the cycle counter, and go to WAIT_DONE.
REQ-012 In WAIT_DONE the counter SHALL increment every cycle, saturating at 2**32-1. When i_complete=1, the FSM SHALL copy the count to o_cycles and go to RD_ADDR. i_complete SHALL be ignored in all other states.
REQ-013 Readout:
- RD_ADDR drives ena=1, wea=0, addr=k.
- RD_CAP registers i_state_dout into m_out_data.
- OUT holds m_out_valid=1 until m_out_ready.
- On handshake, if k=DEPTH-1 go to DONE, else k+1 and go to RD_ADDR.
- m_out_data SHALL stay stable while valid and not ready.
REQ-014 DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-015 o_busy=1 in every state except IDLE.
REQ-016 i_go outside IDLE SHALL be ignored.
REQ-017 o_ctx_data SHALL equal s_ctx_data whenever o_ctx_en=1.
REQ-018 All strobes (o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea, o_start, m_out_valid, o_done) SHALL be 0 outside their owning states.

Reset
REQ-019 rst=1 SHALL immediately force state IDLE and set all outputs to 0, including o_cycles and o_error, regardless of the current state.
REQ-020 After rst deasserts, the first i_go SHALL start a clean run; partial context or state contents from an interrupted run are not cleared.

Configuration
REQ-021 Macro QEA_SEQ_TIMEOUT_EN:
- Defined: in WAIT_DONE, if the counter reaches TIMEOUT_CYCLES without i_complete, SHALL set o_error, load o_cycles, skip readout, and go to DONE.
- Undefined: WAIT_DONE waits indefinitely and TIMEOUT_CYCLES is unused.

Verification
REQ-022 qbit_num=8, ins_num=111, context stream always valid -> 111 ctx writes at addr 0..110, then 64 state writes with only word 0 = 0x40000000 in the top DATA_WIDTH bits, then one o_start pulse.
REQ-023 QEA model raises i_complete 500 cycles after o_start -> o_cycles=500; 64 readout beats in address order; o_done pulses once; o_error=0.
REQ-024 m_out_ready toggled 1-of-3 cycles during readout -> no dropped or duplicated words; data stable while stalled.
REQ-025 s_ctx_valid gapped randomly, i_go pulsed mid-run -> ctx addresses contiguous; second go ignored; exactly one run completes.
REQ-026 i_qbit_num=1 -> o_error=1, o_done pulse, and no ctx, state or start activity.
REQ-027 rst asserted during WAIT_DONE -> all outputs 0 in the same cycle; a subsequent run with QEA_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100 and i_complete stuck at 0 -> o_error=1, o_cycles=100, no readout.
